// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control sequencer (IF -> ID -> EX -> MEM -> WB)
// with PC/IR write enables and ready handshakes to variable-latency memories.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode traps in S_TRAP and
// raises a sticky illegal_op output; otherwise an unknown opcode is a NOP).
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       i_ready,
  input  logic       d_ready,
  output logic       I_req,
  output logic       PC_write,
  output logic       IR_write,
  output logic       RegDst,
  output logic       RegWrite,
  output logic [1:0] ALU_op,
  output logic       ALU_src,
  output logic       Mem_w,
  output logic       Mem_r,
  output logic       Mem_to_Reg,
  output logic       retire,
  output logic       mem_timeout,
  output logic [2:0] state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd6;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_SUBIU = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b010001;
  localparam logic [5:0] OP_SLTI  = 6'b101010;

  // Last wait count before the timeout fires, and the saturation ceiling.
  localparam logic [CNT_W-1:0] LP_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_SAT   = CNT_W'(TIMEOUT);

  logic [2:0]       r_state;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_timeout;
  logic [2:0]       w_next;
  logic             w_wait;
  logic             w_limit;
  logic             w_in_alu;

  assign w_limit = (TIMEOUT != 0) && (r_wait_cnt == LP_LIMIT);

  // Next-state decode; ready wins over the timeout in the limit cycle.
  always_comb begin
    w_next = r_state;
    w_wait = 1'b0;
    case (r_state)
      S_IF: begin
        if (i_ready) w_next = S_ID;
        else begin
          w_wait = 1'b1;
          if (w_limit) w_next = S_ERR;
        end
      end
      S_ID: w_next = S_EX;
      S_EX: begin
        case (r_op_q)
          OP_R, OP_SUBIU, OP_SLTI: w_next = S_WB;
          OP_LW, OP_SW:            w_next = S_MEM;
`ifdef ILLEGAL_TRAP_EN
          default:                 w_next = S_TRAP;
`else
          default:                 w_next = S_IF;
`endif
        endcase
      end
      S_MEM: begin
        if (d_ready) w_next = (r_op_q == OP_LW) ? S_WB : S_IF;
        else begin
          w_wait = 1'b1;
          if (w_limit) w_next = S_ERR;
        end
      end
      S_WB:    w_next = S_IF;
      default: w_next = r_state;  // S_ERR / S_TRAP hold until reset
    endcase
  end

  // State, captured opcode, wait counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IF;
      r_op_q        <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID) r_op_q <= opcode;
      if (w_next != r_state)                    r_wait_cnt <= '0;
      else if (w_wait && r_wait_cnt != LP_SAT)  r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_next == S_ERR) r_mem_timeout <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal_op;

  // Sticky illegal-opcode flag, set on entry to S_TRAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_illegal_op <= 1'b0;
    else if (w_next == S_TRAP) r_illegal_op <= 1'b1;
  end

  assign illegal_op = r_illegal_op;
`endif

  assign w_in_alu = (r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB);

  // Strobe decode: purely combinational from state, op_q and the ready inputs.
  always_comb begin
    I_req      = (r_state == S_IF);
    PC_write   = (r_state == S_IF) && i_ready && !rst;
    IR_write   = (r_state == S_IF) && i_ready && !rst;
    RegDst     = (r_state == S_WB) && (r_op_q == OP_R);
    RegWrite   = (r_state == S_WB);
    Mem_to_Reg = (r_state == S_WB) && (r_op_q == OP_LW);
    Mem_r      = (r_state == S_MEM) && (r_op_q == OP_LW);
    Mem_w      = (r_state == S_MEM) && (r_op_q == OP_SW);
    retire     = (r_state == S_WB) || ((r_state == S_MEM) && (r_op_q == OP_SW) && d_ready);
    ALU_op     = 2'b00;
    ALU_src    = 1'b0;
    if (w_in_alu) begin
      case (r_op_q)
        OP_R:         begin ALU_op = 2'b10; ALU_src = 1'b0; end
        OP_SUBIU:     begin ALU_op = 2'b01; ALU_src = 1'b1; end
        OP_LW, OP_SW: begin ALU_op = 2'b00; ALU_src = 1'b1; end
        OP_SLTI:      begin ALU_op = 2'b11; ALU_src = 1'b1; end
        default:      begin ALU_op = 2'b00; ALU_src = 1'b0; end
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver issues instructions with
// random memory wait profiles and pushes the expected per-instruction summary;
// a negedge monitor closes each instruction when the DUT returns to fetch and
// compares. Directed checks cover reset, timeout and reset-mid-store.
module tb_multicycle_control;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_SUBIU = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b010001;
  localparam logic [5:0] OP_SLTI  = 6'b101010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h2a;
  logic       i_ready = 1'b1;
  logic       d_ready = 1'b1;
  logic       I_req, PC_write, IR_write, RegDst, RegWrite, ALU_src;
  logic       Mem_w, Mem_r, Mem_to_Reg, retire, mem_timeout;
  logic [1:0] ALU_op;
  logic [2:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  multicycle_control #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .i_ready(i_ready), .d_ready(d_ready),
    .I_req(I_req), .PC_write(PC_write), .IR_write(IR_write), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALU_op(ALU_op), .ALU_src(ALU_src), .Mem_w(Mem_w),
    .Mem_r(Mem_r), .Mem_to_Reg(Mem_to_Reg), .retire(retire),
    .mem_timeout(mem_timeout), .state(state)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int lat; int ret; int memr; int memw; int regw; int pcw;
    int regdst; int mtr; int aluop; int alusrc; int chk_alu; int held_bad;
  } rec_t;

  rec_t expq[$];

  // Reference: per-instruction summary from the opcode class and wait counts.
  function automatic rec_t model(input logic [5:0] op, input int iw, input int dw);
    rec_t e;
    bit is_r, is_alu, is_ld, is_st;
    is_r   = (op == OP_R);
    is_alu = is_r || (op == OP_SUBIU) || (op == OP_SLTI);
    is_ld  = (op == OP_LW);
    is_st  = (op == OP_SW);
    e = '{default: 0};
    e.lat = (iw + 1) + 1 + 1;                   // fetch (+waits), decode, execute
    if (is_ld || is_st)  e.lat += dw + 1;       // memory (+waits)
    if (is_alu || is_ld) e.lat += 1;            // writeback
    e.ret     = (is_alu || is_ld || is_st) ? 1 : 0;
    e.memr    = is_ld ? dw + 1 : 0;
    e.memw    = is_st ? dw + 1 : 0;
    e.regw    = (is_alu || is_ld) ? 1 : 0;
    e.pcw     = 1;
    e.regdst  = is_r ? 1 : 0;
    e.mtr     = is_ld ? 1 : 0;
    e.aluop   = is_r ? 2 : (op == OP_SUBIU) ? 1 : (op == OP_SLTI) ? 3 : 0;
    e.alusrc  = is_r ? 0 : 1;
    e.chk_alu = e.ret;
    return e;
  endfunction

  // Monitor state
  logic       mon_en = 1'b0;
  logic [2:0] prev_st = 3'd7;
  bit         open_rec = 0;
  rec_t       ob;

  task automatic close_rec(input rec_t o);
    rec_t e;
    if (expq.size() == 0) begin
      chk("queue_underflow", 1, 0);
      return;
    end
    e = expq.pop_front();
    chk("latency",  o.lat,  e.lat);
    chk("retire",   o.ret,  e.ret);
    chk("mem_r",    o.memr, e.memr);
    chk("mem_w",    o.memw, e.memw);
    chk("regwrite", o.regw, e.regw);
    chk("pc_write", o.pcw,  e.pcw);
    chk("regdst",   o.regdst, e.regdst);
    chk("mem2reg",  o.mtr,  e.mtr);
    if (e.chk_alu != 0) begin
      chk("alu_op",  o.aluop,  e.aluop);
      chk("alu_src", o.alusrc, e.alusrc);
    end
    chk("alu_held", o.held_bad, 0);
  endtask

  // Each return to S_IF closes the previous instruction and opens a new one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (state == 3'd0 && prev_st != 3'd0) begin
        if (open_rec) close_rec(ob);
        ob = '{default: 0};
        open_rec = 1;
      end
      if (open_rec) begin
        ob.lat++;
        ob.ret  += int'(retire);
        ob.memr += int'(Mem_r);
        ob.memw += int'(Mem_w);
        ob.regw += int'(RegWrite);
        ob.pcw  += int'(PC_write && IR_write);
        if (RegWrite) begin
          ob.regdst = int'(RegDst);
          ob.mtr    = int'(Mem_to_Reg);
        end
        if (state == 3'd2) begin
          ob.aluop  = int'(ALU_op);
          ob.alusrc = int'(ALU_src);
        end else if ((state == 3'd3 || state == 3'd4) &&
                     (int'(ALU_op) != ob.aluop || int'(ALU_src) != ob.alusrc)) begin
          ob.held_bad = 1;
        end
      end
      prev_st = state;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction open-loop against the expected cycle schedule.
  task automatic run_instr(input logic [5:0] op, input int iw, input int dw);
    bit has_mem, has_wb, known;
    has_mem = (op == OP_LW) || (op == OP_SW);
    known   = has_mem || (op == OP_R) || (op == OP_SUBIU) || (op == OP_SLTI);
    has_wb  = known && (op != OP_SW);
    expq.push_back(model(op, iw, dw));
    for (int c = 0; c <= iw; c++) begin
      opcode = op; i_ready = (c == iw); d_ready = 1'($urandom);
      step();
    end
    opcode = op; i_ready = 1'($urandom); d_ready = 1'($urandom);  // ID
    step();
    opcode = 6'($urandom); i_ready = 1'($urandom); d_ready = 1'($urandom);  // EX
    step();
    if (has_mem) begin
      for (int c = 0; c <= dw; c++) begin
        d_ready = (c == dw); i_ready = 1'($urandom); opcode = 6'($urandom);
        step();
      end
    end
    if (has_wb) begin
      i_ready = 1'($urandom); d_ready = 1'($urandom); opcode = 6'($urandom);
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; i_ready = 1'b0; d_ready = 1'b0;
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_mem_timeout", int'(mem_timeout), 0);
    rst = 1'b0;
  endtask

  function automatic logic [5:0] pick_op();
    int k;
    logic [5:0] x;
`ifdef ILLEGAL_TRAP_EN
    k = $urandom_range(0, 4);
`else
    k = $urandom_range(0, 5);
`endif
    case (k)
      0: return OP_R;
      1: return OP_SUBIU;
      2: return OP_SW;
      3: return OP_LW;
      4: return OP_SLTI;
      default: begin
        x = 6'h3f;
        for (int t = 0; t < 8; t++) begin
          x = 6'($urandom);
          if (x != OP_R && x != OP_SUBIU && x != OP_SW && x != OP_LW && x != OP_SLTI) break;
          x = 6'h3f;
        end
        return x;
      end
    endcase
  endfunction

  initial begin
    int n;
    // Reset state with both readies high: only I_req may be set.
    #3;
    chk("reset_state",    int'(state), 0);
    chk("reset_ireq",     int'(I_req), 1);
    chk("reset_pcwrite",  int'(PC_write), 0);
    chk("reset_irwrite",  int'(IR_write), 0);
    chk("reset_regwrite", int'(RegWrite), 0);
    chk("reset_memr",     int'(Mem_r), 0);
    chk("reset_memw",     int'(Mem_w), 0);
    chk("reset_retire",   int'(retire), 0);
    chk("reset_alu_op",   int'(ALU_op), 0);
    chk("reset_timeout",  int'(mem_timeout), 0);
    step();
    chk("reset_hold_state", int'(state), 0);
    rst = 1'b0; i_ready = 1'b0; d_ready = 1'b0;

    // Scoreboarded instruction stream: directed prefix then random.
    prev_st = 3'd7; open_rec = 0; mon_en = 1'b1;
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 1, 2);
    run_instr(OP_SLTI, 0, 0);
    run_instr(OP_SUBIU, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    run_instr(6'h3f, 0, 0);
    run_instr(6'h3f, 2, 0);
`endif
    for (int i = 0; i < 40; i++)
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 4));
    i_ready = 1'b0; d_ready = 1'b0;
    step(); step();
    mon_en = 1'b0;
    chk("queue_drained", expq.size(), 0);

    // Fetch timeout: 16 S_IF cycles then S_ERR, sticky until reset.
    do_reset();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (state != 3'd0) break;
      n++;
    end
    chk("timeout_if_cycles", n, 16);
    chk("timeout_state", int'(state), 5);
    chk("timeout_flag", int'(mem_timeout), 1);
    chk("timeout_ireq", int'(I_req), 0);
    i_ready = 1'b1; d_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("timeout_sticky_state", int'(state), 5);
    chk("timeout_sticky_flag", int'(mem_timeout), 1);

    // Ready in the limit cycle wins over the timeout.
    do_reset();
    i_ready = 1'b0;
    repeat (15) step();
    i_ready = 1'b1;
    @(negedge clk);
    chk("limit_ready_state", int'(state), 0);
    chk("limit_ready_pcwrite", int'(PC_write), 1);
    @(negedge clk);
    chk("limit_ready_next", int'(state), 1);
    chk("limit_ready_flag", int'(mem_timeout), 0);

    // Reset in the middle of a stalled store.
    do_reset();
    opcode = OP_SW; i_ready = 1'b1; d_ready = 1'b0;
    repeat (4) step();
    #2;
    chk("sw_stall_state", int'(state), 3);
    chk("sw_stall_memw", int'(Mem_w), 1);
    d_ready = 1'b1; rst = 1'b1;
    #1;
    chk("sw_rst_memw", int'(Mem_w), 0);
    chk("sw_rst_state", int'(state), 0);
    chk("sw_rst_retire", int'(retire), 0);
    step();
    rst = 1'b0;

`ifdef ILLEGAL_TRAP_EN
    // Unknown opcode traps and holds.
    do_reset();
    opcode = 6'h3f; i_ready = 1'b1; d_ready = 1'b1;
    repeat (3) step();
    chk("trap_state", int'(state), 6);
    chk("trap_flag", int'(illegal_op), 1);
    chk("trap_ireq", int'(I_req), 0);
    repeat (4) step();
    chk("trap_hold_state", int'(state), 6);
    chk("trap_hold_flag", int'(illegal_op), 1);
    do_reset();
    chk("trap_cleared", int'(illegal_op), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the single-cycle datapath's control signal set.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and issues the same strobe set per step: RegDst, RegWrite, ALU_op, ALU_src, Mem_w, Mem_r, Mem_to_Reg.
- Adds PC/IR write enables and ready-based handshakes to variable-latency instruction and data memories.
- Sits between the IR opcode field and the datapath muxes and enables.

Parameters:
- TIMEOUT, 16: maximum consecutive wait cycles allowed in S_IF or S_MEM. 0 disables the timeout.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26].
- i_ready  input  1  instruction memory has data valid this cycle.
- d_ready  input  1  data memory read/write completes this cycle.
- I_req  output  1  instruction fetch request.
- PC_write  output  1  load PC with PC+4.
- IR_write  output  1  load IR.
- RegDst  output  1  1 selects rd, 0 selects rt.
- RegWrite  output  1  register file write enable.
- ALU_op  output  2  00 add, 01 subiu, 10 R-type funct, 11 slti.
- ALU_src  output  1  1 selects immediate.
- Mem_w  output  1  data memory write request.
- Mem_r  output  1  data memory read request.
- Mem_to_Reg  output  1  1 selects memory data for writeback.
- retire  output  1  one-cycle pulse when an instruction completes.
- mem_timeout  output  1  sticky error flag.
- state  output  3  current state, for debug.

Behaviour:
- State encoding: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_ERR=5, S_TRAP=6.
- Opcodes: R_TYPE=000000, SUBIU=001101, SW=010000, LW=010001, SLTI=101010.
- Reset (async, rst=1): state=S_IF, op_q=0, wait_cnt=0, mem_timeout=0. All outputs go to 0 immediately except I_req=1 (S_IF decode). PC_write and IR_write stay 0 while rst=1.
- Output timing: all outputs are combinational from state, op_q and the ready inputs. There are no registered output delays.
- S_IF: I_req=1. PC_write = IR_write = i_ready. On i_ready go to S_ID, otherwise stay.
- S_ID: op_q <= opcode at the clock edge. Go to S_EX. All strobes 0.
- S_EX: ALU_op/ALU_src from op_q: R 10/0, SUBIU 01/1, LW 00/1, SW 00/1, SLTI 11/1.
  - R, SUBIU, SLTI go to S_WB.
  - LW, SW go to S_MEM.
  - Unknown opcode goes to S_IF with no retire (NOP).
- ALU_op and ALU_src stay held at the S_EX values through S_MEM and S_WB. In S_IF and S_ID they are 00/0.
- S_MEM: Mem_r=1 for LW, Mem_w=1 for SW, held until d_ready.
  - On d_ready, LW goes to S_WB.
  - On d_ready, SW goes to S_IF and retire=1.
- S_WB: RegWrite=1. RegDst=1 only for R. Mem_to_Reg=1 only for LW. Go to S_IF with retire=1.
- Latency with zero-wait memories:
  - R, SUBIU, SLTI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Unknown opcode: 3 cycles.
  - Each wait cycle adds one.
- wait_cnt rules:
  - Clears on every state change.
  - Increments in S_IF when i_ready=0 and in S_MEM when d_ready=0.
  - Saturates at TIMEOUT.
- Timeout: if TIMEOUT≠0 and wait_cnt==TIMEOUT-1 with ready still low, go to S_ERR.
- Ready wins over timeout: ready asserted in the limit cycle proceeds normally.
- S_ERR: mem_timeout=1, all strobes 0. Stays in S_ERR until rst.
- Reset mid-instruction: the in-flight Mem_w/Mem_r/RegWrite drop asynchronously. There is no partial retire.
- Ready inputs are ignored outside their own states. i_ready in S_MEM has no effect.
- op_q is stable from S_EX until the next S_ID, regardless of opcode changes on the input.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in S_EX goes to S_TRAP.
  - S_TRAP: all strobes 0, I_req=0, state=6.
  - Stays in S_TRAP until rst.
  - Output illegal_op (1 bit, reset 0) is set to 1 on entry and held.
- Undefined: unknown opcode is a NOP as described in Behaviour. Port illegal_op is absent and state 6 is unreachable.

Test Plan:
- Zero-wait R_TYPE (i_ready=1), opcode=000000:
  - states 0,1,2,4,0.
  - In S_WB: RegWrite=1, RegDst=1, ALU_op=10.
  - retire pulses in cycle 4.
- LW, opcode=010001, d_ready low for 3 cycles:
  - Mem_r=1 held 4 cycles.
  - Then S_WB with Mem_to_Reg=1, RegWrite=1, ALU_op=00, ALU_src=1.
  - Total latency 8 cycles.
- SW, opcode=010000:
  - Mem_w=1 until d_ready.
  - Goes directly to S_IF with retire=1.
  - RegWrite never asserted.
- SLTI then SUBIU back-to-back, with opcode changed to 000000 during S_EX:
  - ALU_op=11/ALU_src=1, then 01/1, from the captured op_q.
  - RegDst=0 for both.
- TIMEOUT=16, i_ready held 0:
  - S_ERR entered after 16 S_IF cycles, mem_timeout=1.
  - With i_ready=1 on the 16th cycle instead: normal S_ID.
- rst asserted mid S_MEM of SW:
  - Mem_w drops the same cycle, state=0, no retire.
- Opcode 111111:
  - Without ILLEGAL_TRAP_EN: back to S_IF after S_EX.
  - With ILLEGAL_TRAP_EN: state=6, illegal_op=1 until reset.
